// File: rtl/psram_master_if.sv
`timescale 1ns/1ps
// psram_master_if: request/response handshake and quad-SPI PSRAM pin bundle.
//   master : psram_master side (drives req_ready, rsp_*, sck, ce_n, dio_out, dio_oe)
//   slave  : environment side (drives req_*, rsp_ready, dio_in)
interface psram_master_if;
    localparam int unsigned ADDR_W = 22;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 2;
    localparam int unsigned DIO_W  = 4;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              sck;
    logic              ce_n;
    logic [DIO_W-1:0]  dio_out;
    logic [DIO_W-1:0]  dio_oe;
    logic [DIO_W-1:0]  dio_in;

    modport master (
        input  req_valid, req_write, req_addr, req_len, req_wdata, rsp_ready, dio_in,
        output req_ready, rsp_valid, rsp_rdata, sck, ce_n, dio_out, dio_oe
    );

    modport slave (
        output req_valid, req_write, req_addr, req_len, req_wdata, rsp_ready, dio_in,
        input  req_ready, rsp_valid, rsp_rdata, sck, ce_n, dio_out, dio_oe
    );
endinterface

// File: rtl/psram_master.sv
`timescale 1ns/1ps
// psram_master: single-request quad-SPI PSRAM master (cmd 0x38 write / 0xEB read,
// 1-4 byte bursts, sck = clk/2, minimum ce_n high time of DESEL_CYCLES clocks).
//   clk_i, rst_i : system clock, asynchronous active-high reset
//   bus          : psram_master_if.master (request, response and PSRAM pins)
module psram_master #(
    parameter int unsigned DESEL_CYCLES = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    psram_master_if.master bus
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned TX_W  = 56;
    localparam logic [7:0]  CMD_WRITE = 8'h38;
    localparam logic [7:0]  CMD_READ  = 8'hEB;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, DESEL, RESP} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] desel_cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       cmd_q;
    logic [TX_W-1:0]  tx_q;
    logic             write_q;
    logic [1:0]       len_q;
    logic [31:0]      acc_q;
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic [31:0]      rsp_rdata_q;
    logic             sck_q;
    logic             ce_n_q;
    logic [3:0]       dio_out_q;
    logic [3:0]       dio_oe_q;
    logic [7:0]       cmd_sel_c;
    logic [IDX_W-1:0] last_idx_c;

    assign cmd_sel_c  = bus.req_write ? CMD_WRITE : CMD_READ;
    // Index of the final data nibble: 2 * bytes - 1.
    assign last_idx_c = {len_q, 1'b1};

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.sck       = sck_q;
    assign bus.ce_n      = ce_n_q;
    assign bus.dio_out   = dio_out_q;
    assign bus.dio_oe    = dio_oe_q;

    // Transaction sequencer. Pin data only changes on edges that drive sck low.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= DESEL;
            desel_cnt_q <= CNT_W'(DESEL_CYCLES);
            idx_q       <= '0;
            cmd_q       <= '0;
            tx_q        <= '0;
            write_q     <= 1'b0;
            len_q       <= '0;
            acc_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            sck_q       <= 1'b0;
            ce_n_q      <= 1'b1;
            dio_out_q   <= '0;
            dio_oe_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        req_ready_q <= 1'b0;
                        write_q     <= bus.req_write;
                        len_q       <= bus.req_len;
                        acc_q       <= '0;
                        ce_n_q      <= 1'b0;
                        sck_q       <= 1'b0;
                        dio_oe_q    <= 4'hF;
                        dio_out_q   <= {3'b000, cmd_sel_c[7]};
                        cmd_q       <= {cmd_sel_c[6:0], 1'b0};
                        // Address then write bytes, byte 0 first, high nibble first.
                        tx_q        <= {2'b00, bus.req_addr,
                                        bus.req_wdata[7:0],   bus.req_wdata[15:8],
                                        bus.req_wdata[23:16], bus.req_wdata[31:24]};
                        idx_q       <= '0;
                        state_q     <= CMD;
                    end
                end
                CMD, ADDR, WDATA, RDATA: begin
                    sck_q <= ~sck_q;
                    if (!sck_q) begin
                        // Rising sck edge: read nibble j lands at bit 4*j (low nibble first).
                        if (state_q == RDATA) begin
                            acc_q[{idx_q, 2'b00} +: 4] <= bus.dio_in;
                        end
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                        case (state_q)
                            CMD: begin
                                if (idx_q == IDX_W'(7)) begin
                                    state_q   <= ADDR;
                                    idx_q     <= '0;
                                    dio_out_q <= tx_q[TX_W-1 -: 4];
                                    tx_q      <= tx_q << 4;
                                end else begin
                                    dio_out_q <= {3'b000, cmd_q[7]};
                                    cmd_q     <= cmd_q << 1;
                                end
                            end
                            ADDR: begin
                                if (idx_q == IDX_W'(5)) begin
                                    idx_q <= '0;
                                    if (write_q) begin
                                        state_q   <= WDATA;
                                        dio_out_q <= tx_q[TX_W-1 -: 4];
                                        tx_q      <= tx_q << 4;
                                    end else begin
                                        // Turnaround: release the bus one clock before rise 15.
                                        state_q   <= RDATA;
                                        dio_oe_q  <= '0;
                                        dio_out_q <= '0;
                                    end
                                end else begin
                                    dio_out_q <= tx_q[TX_W-1 -: 4];
                                    tx_q      <= tx_q << 4;
                                end
                            end
                            WDATA, RDATA: begin
                                if (idx_q == last_idx_c) begin
                                    state_q     <= DESEL;
                                    desel_cnt_q <= CNT_W'(DESEL_CYCLES);
                                    ce_n_q      <= 1'b1;
                                    dio_oe_q    <= '0;
                                    dio_out_q   <= '0;
                                    rsp_valid_q <= 1'b1;
                                    rsp_rdata_q <= write_q ? 32'h0 : acc_q;
                                end else if (state_q == WDATA) begin
                                    dio_out_q <= tx_q[TX_W-1 -: 4];
                                    tx_q      <= tx_q << 4;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                DESEL: begin
                    // Response may complete before or after the deselect time runs out.
                    if (rsp_valid_q && bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                    end
                    if (desel_cnt_q <= CNT_W'(1)) begin
                        if (!rsp_valid_q || bus.rsp_ready) begin
                            state_q     <= IDLE;
                            req_ready_q <= 1'b1;
                        end else begin
                            state_q <= RESP;
                        end
                    end else begin
                        desel_cnt_q <= desel_cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= DESEL;
                    desel_cnt_q <= CNT_W'(DESEL_CYCLES);
                    ce_n_q      <= 1'b1;
                    sck_q       <= 1'b0;
                    dio_oe_q    <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_psram_master.sv
`timescale 1ns/1ps
// tb_psram_master: random and directed requests against a byte-array memory
// reference; a pin-level PSRAM device model decodes the bus and serves reads.
module tb_psram_master;
    localparam int unsigned DESEL    = 3;
    localparam int          MEM_SIZE = 4194304;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    psram_master_if bus();

    psram_master #(.DESEL_CYCLES(DESEL)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference memory (request level) and device memory (decoded from pins).
    logic [7:0] ref_mem [int];
    logic [7:0] dev_mem [int];

    function automatic logic [7:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] dev_rd(input int a);
        return dev_mem.exists(a) ? dev_mem[a] : 8'h00;
    endfunction

    // Device model / pin monitor, sampled away from the active edge.
    logic        prev_sck = 1'b0;
    logic        prev_ce  = 1'b1;
    int          mon_rises = 0;
    int          mon_start = 0;
    int          mon_end = 0;
    int          mon_gap = 0;
    int          last_ce_rise = 0;
    int          proto_err = 0;
    logic [7:0]  mon_cmd = 8'h00;
    logic [23:0] mon_addr = 24'h0;
    logic [31:0] mon_wdata = 32'h0;
    int          mj;
    logic [7:0]  mb;

    always @(negedge clk) begin
        bus.dio_in = 4'h0;
        if (rst) begin
            mon_rises    = 0;
            last_ce_rise = cyc;
        end else begin
            if (bus.ce_n && bus.sck) proto_err++;
            if (bus.req_ready && bus.rsp_valid) proto_err++;
            if (!bus.ce_n && prev_ce) begin
                mon_start = cyc;
                mon_gap   = cyc - last_ce_rise;
                mon_rises = 0;
                mon_cmd   = 8'h00;
                mon_addr  = 24'h0;
                mon_wdata = 32'h0;
            end
            if (!bus.ce_n && bus.sck && !prev_sck) begin
                mon_rises++;
                if (mon_rises <= 8) begin
                    mon_cmd = {mon_cmd[6:0], bus.dio_out[0]};
                    if (bus.dio_oe !== 4'hF || bus.dio_out[3:1] !== 3'b000) proto_err++;
                end else if (mon_rises <= 14) begin
                    mon_addr = {mon_addr[19:0], bus.dio_out};
                    if (bus.dio_oe !== 4'hF) proto_err++;
                end else if (mon_cmd == 8'h38) begin
                    mj = mon_rises - 15;
                    if (mj < 8) mon_wdata[8*(mj/2) + ((mj % 2 == 0) ? 4 : 0) +: 4] = bus.dio_out;
                    if (bus.dio_oe !== 4'hF) proto_err++;
                end else if (bus.dio_oe !== 4'h0) begin
                    proto_err++;
                end
            end
            if (!bus.ce_n && !bus.sck && mon_cmd == 8'hEB && mon_rises >= 14) begin
                if (bus.dio_oe !== 4'h0) proto_err++;
                mj = mon_rises - 14;
                mb = dev_rd((int'(mon_addr[21:0]) + mj / 2) % MEM_SIZE);
                bus.dio_in = (mj % 2 == 0) ? mb[3:0] : mb[7:4];
            end
            if (bus.ce_n && !prev_ce) begin
                mon_end      = cyc;
                last_ce_rise = cyc;
                if (mon_cmd == 8'h38) begin
                    for (int i = 0; i < (mon_rises - 14) / 2; i++)
                        dev_mem[(int'(mon_addr[21:0]) + i) % MEM_SIZE] = mon_wdata[8*i +: 8];
                end
            end
        end
        prev_sck = bus.sck;
        prev_ce  = bus.ce_n;
    end

    logic [31:0] last_rsp;

    // One complete request/response; hold = cycles rsp_ready stays low after rsp_valid.
    task automatic run_txn(input logic wr, input logic [21:0] addr, input logic [1:0] len,
                           input logic [31:0] wd, input int hold);
        int          n;
        int          t0;
        int          tr;
        int          guard;
        logic [31:0] exp_rd;
        logic [31:0] exp_wd;
        n      = int'(len) + 1;
        exp_rd = 32'h0;
        exp_wd = 32'h0;
        for (int i = 0; i < n; i++) begin
            if (!wr) exp_rd[8*i +: 8] = ref_rd((int'(addr) + i) % MEM_SIZE);
            exp_wd[8*i +: 8] = wd[8*i +: 8];
        end
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_len   = len;
        bus.req_wdata = wd;
        bus.rsp_ready = (hold == 0);
        guard = 0;
        while (!bus.req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("accept", 32'(guard < 200), 32'd1);
        @(negedge clk);
        t0 = cyc;
        bus.req_valid = 1'b0;
        check("rdy_drop", 32'(bus.req_ready), 32'd0);
        guard = 0;
        while (!bus.rsp_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        tr = cyc;
        last_rsp = bus.rsp_rdata;
        check("latency", 32'(tr - t0), 32'(28 + 4 * n));
        check("rdata", bus.rsp_rdata, exp_rd);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check("hold_flags", 32'({bus.rsp_valid, bus.req_ready}), 32'h2);
            check("hold_data", bus.rsp_rdata, exp_rd);
            bus.rsp_ready = 1'b1;
            @(negedge clk);
            check("handshake", 32'({bus.rsp_valid, bus.req_ready}), 32'(hold + 1 >= int'(DESEL)));
        end else begin
            @(negedge clk);
        end
        check("cmd", 32'(mon_cmd), wr ? 32'h38 : 32'hEB);
        check("addr", 32'(mon_addr), 32'(addr));
        check("rises", 32'(mon_rises), 32'(14 + 2 * n));
        check("ce_low", 32'(mon_end - mon_start), 32'(28 + 4 * n));
        check("t0", 32'(mon_start), 32'(t0));
        check("desel_gap", 32'(mon_gap >= int'(DESEL)), 32'd1);
        if (wr) begin
            check("wdata", mon_wdata, exp_wd);
            for (int i = 0; i < n; i++) ref_mem[(int'(addr) + i) % MEM_SIZE] = wd[8*i +: 8];
        end
    endtask

    // Write that is cut off by reset around sck rise 18.
    task automatic abort_write(input logic [21:0] addr);
        int guard;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = addr;
        bus.req_len   = 2'd3;
        bus.req_wdata = 32'hFFEEDDCC;
        bus.rsp_ready = 1'b1;
        guard = 0;
        while (!bus.req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        guard = 0;
        while (mon_rises < 18 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("abort_reach", 32'(guard < 100), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_pins", 32'({bus.ce_n, bus.sck, bus.dio_oe}), 32'h20);
        guard = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid) guard++;
        end
        rst = 1'b0;
        repeat (DESEL + 2) begin
            @(negedge clk);
            if (bus.rsp_valid) guard++;
        end
        check("abort_norsp", 32'(guard), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        wr;
        logic [21:0] a;
        logic [1:0]  l;
        logic [31:0] d;
        int          h;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 22'h0;
        bus.req_len   = 2'd0;
        bus.req_wdata = 32'h0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pins", 32'({bus.ce_n, bus.sck, bus.dio_oe, bus.dio_out, bus.req_ready, bus.rsp_valid}),
              32'h800);
        check("rst_rdata", bus.rsp_rdata, 32'h0);
        rst = 1'b0;
        for (int i = 1; i < int'(DESEL); i++) begin
            @(negedge clk);
            check("rdy_early", 32'(bus.req_ready), 32'd0);
        end
        @(negedge clk);
        check("rdy_rise", 32'(bus.req_ready), 32'd1);

        run_txn(1'b1, 22'h000010, 2'd3, 32'hDDCCBBAA, 0);
        run_txn(1'b0, 22'h000010, 2'd3, 32'h0, 0);
        check("rd_known", last_rsp, 32'hDDCCBBAA);
        run_txn(1'b1, 22'h3FFFFF, 2'd0, 32'h0000005A, 0);
        run_txn(1'b0, 22'h3FFFFF, 2'd0, 32'h0, 0);
        check("rd_top", last_rsp, 32'h0000005A);
        run_txn(1'b1, 22'h3FFFFE, 2'd3, 32'h44332211, 2);
        run_txn(1'b0, 22'h000000, 2'd1, 32'h0, 20);
        check("rd_wrap", last_rsp, 32'h00004433);

        run_txn(1'b1, 22'h000020, 2'd3, 32'h87654321, 0);
        abort_write(22'h000020);
        run_txn(1'b0, 22'h000020, 2'd3, 32'h0, 0);
        check("abort_rd", last_rsp, 32'h87654321);

        for (int t = 0; t < 40; t++) begin
            wr = 1'($urandom_range(0, 1));
            a  = (($urandom_range(0, 1) == 1) ? 22'h3FFFF0 : 22'h000000) + 22'($urandom_range(0, 15));
            l  = 2'($urandom_range(0, 3));
            d  = $urandom;
            h  = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 2));
            run_txn(wr, a, l, d, h);
        end

        check("protocol", 32'(proto_err), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/psram_master.md
PSRAM_MASTER -- requirements
Module: psram_master

Interface
REQ-001 Parameter: DESEL_CYCLES, default 2, minimum number of clock cycles ce_n stays high between two transactions (legal range 1..15).
REQ-002 clock  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset, asynchronous and active-high.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  request accepted when req_valid and req_ready are both high on a clock edge.
REQ-006 req_write  input  1  1 = write (cmd 0x38), 0 = read (cmd 0xEB).
REQ-007 req_addr  input  22  byte address within the 4 MiB device.
REQ-008 req_len  input  2  byte count minus 1 (1..4 bytes).
REQ-009 req_wdata  input  32  write bytes, byte i in bits [8i+7:8i].
REQ-010 rsp_valid  output  1  transaction complete; held until rsp_ready.
REQ-011 rsp_ready  input  1  response consumed.
REQ-012 rsp_rdata  output  32  read bytes, byte i in [8i+7:8i]; unread bytes and write responses are 0.
REQ-013 sck  output  1  PSRAM serial clock, registered.
REQ-014 ce_n  output  1  PSRAM chip enable, active-low, registered.
REQ-015 dio_out  output  4  data driven toward the PSRAM.
REQ-016 dio_oe  output  4  per-bit output enable; the top level builds the inout from dio_out/dio_oe.
REQ-017 dio_in  input  4  data sampled from the PSRAM pins.

Function
REQ-018 States: IDLE, CMD, ADDR, WDATA, RDATA, DESEL, RESP; req_ready is high only in IDLE.
REQ-019 Acceptance captures write, addr, len and wdata; at that edge (T0) ce_n goes low, sck stays 0, and the FSM enters CMD.
REQ-020 sck period is 2 clocks: sck = 0 for one cycle, then 1 for one cycle; rising edge k (k>=1) occurs at T0+2k-1.
REQ-021 dio_out/dio_oe change only on edges that drive sck low (including T0), so data is stable across every sck rise.
REQ-022 CMD: 8 sck rises, MSB first on dio_out[0]; dio_oe = 4'b1111 with dio_out[3:1] = 0.
REQ-023 ADDR: 6 sck rises (rises 9..14), address {2'b00, addr} MSB nibble first on dio_out[3:0].
REQ-024 WDATA: 2 rises per byte, byte 0 first; for each byte the high nibble goes first, then the low nibble.
REQ-025 RDATA: dio_oe = 0 from the edge that drives sck low after rise 14; contention for that one clock is permitted and nothing is sampled during it.
REQ-026 RDATA sampling: dio_in is sampled on the edge producing rise 15+j (j = 0..2n-1). Even j is the low nibble and odd j is the high nibble of byte j/2.
REQ-027 After the last data rise (rise 14+2n), the next edge (T0+28+4n) drives ce_n = 1, sck = 0 and dio_oe = 0, and enters DESEL with a counter loaded to DESEL_CYCLES.
REQ-028 rsp_valid rises at the same edge as ce_n (T0+28+4n); rsp_rdata is stable while rsp_valid is high.
REQ-029 The FSM returns to IDLE only when the DESEL count has expired and the response handshake has completed, in either order; the RESP state covers a response that is still pending after DESEL.
REQ-030 A burst that runs past address 0x3FFFFF is not split: the address is sent unchanged and the device wraps modulo 4 MiB.
REQ-031 sck is 0 whenever ce_n is high; ce_n never pulses within a transaction.

Reset
REQ-032 While reset is high, and on the first edge after it: ce_n = 1, sck = 0, dio_oe = 0, dio_out = 0, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, FSM = DESEL with the counter at DESEL_CYCLES.
REQ-033 Reset in mid-transaction aborts immediately; no response is issued for the aborted request.
REQ-034 req_ready first rises DESEL_CYCLES clocks after reset deasserts.

Verification
REQ-035 Write addr 0x000010, len 3, wdata 0xDDCCBBAA -> cmd 0x38, address nibbles 0,0,0,0,1,0, data nibbles A,A,B,B,C,C,D,D on rises 15..22; ce_n rises at T0+44; rsp_rdata = 0.
REQ-036 Read back the same address with len 3, using the device model -> rsp_rdata = 0xDDCCBBAA at T0+44; dio_oe = 0 from T0+28.
REQ-037 Read len 0 at 0x3FFFFF after writing 0x5A there -> rsp_rdata = 0x0000005A; exactly 16 sck rises.
REQ-038 Back-to-back requests with rsp_ready held high -> ce_n stays high for at least DESEL_CYCLES clocks between transactions; a new req is never accepted while rsp_valid = 1.
REQ-039 rsp_ready held low for 20 cycles -> rsp_valid and rsp_rdata are held; req_ready stays 0 until one clock after the handshake.
REQ-040 Reset asserted at rise 18 of a write -> ce_n = 1, sck = 0 and dio_oe = 0 immediately; no rsp_valid; the next read returns device data unaffected by the aborted write.
